// File: rtl/e203_ifu_prefetch_pkg.sv
// rtl/e203_ifu_prefetch_pkg.sv - default widths/depths and shared types for the IFU prefetcher
package e203_ifu_prefetch_pkg;

    localparam int E203_PC_W         = 32;
    localparam int E203_INSTR_W      = 32;
    localparam int E203_IFU_OUTS_MAX = 2;
    localparam int E203_IFU_IRQ_DEP  = 4;

    // Source of the next fetch_pc value
    typedef enum logic [1:0] {
        PC_SRC_HOLD  = 2'd0,
        PC_SRC_BOOT  = 2'd1,
        PC_SRC_FLUSH = 2'd2,
        PC_SRC_INCR  = 2'd3
    } pc_src_e;

endpackage

// File: rtl/e203_ifu_ir_fifo.sv
// rtl/e203_ifu_ir_fifo.sv - parametrised sync FIFO with flush; a push in a flush cycle becomes the sole entry
module e203_ifu_ir_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head_data,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW    = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] wr_idx;
    logic [CW-1:0]    cnt;
    logic             empty;
    logic             full;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty   = (cnt == '0);
    assign full    = (cnt == CW'(DEPTH));
    assign do_pop  = pop & ~empty & ~flush;
    assign do_push = push & (flush | ~full | do_pop);
    assign wr_idx  = flush ? '0 : wr_ptr;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_idx] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= do_push ? ptr_inc('0) : '0;
            cnt    <= do_push ? CW'(1) : '0;
        end else begin
            if (do_push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            cnt <= cnt + CW'(do_push) - CW'(do_pop);
        end
    end

    assign head_data = mem[rd_ptr];
    assign count     = cnt;

endmodule

// File: rtl/e203_ifu_prefetch.sv
// rtl/e203_ifu_prefetch.sv - multi-outstanding sequential instruction prefetcher with IR FIFO, flush and halt
module e203_ifu_prefetch
    import e203_ifu_prefetch_pkg::*;
#(
    parameter int PC_W     = E203_PC_W,
    parameter int INSTR_W  = E203_INSTR_W,
    parameter int OUTS_MAX = E203_IFU_OUTS_MAX,
    parameter int FIFO_DEP = E203_IFU_IRQ_DEP
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [PC_W-1:0]    pc_rtvec,
    output logic               ifu_req_valid,
    input  logic               ifu_req_ready,
    output logic [PC_W-1:0]    ifu_req_pc,
    input  logic               ifu_rsp_valid,
    output logic               ifu_rsp_ready,
    input  logic               ifu_rsp_err,
    input  logic [INSTR_W-1:0] ifu_rsp_instr,
    output logic               ifu_o_valid,
    input  logic               ifu_o_ready,
    output logic [INSTR_W-1:0] ifu_o_ir,
    output logic [PC_W-1:0]    ifu_o_pc,
    output logic               ifu_o_buserr,
    output logic               ifu_o_misalgn,
    input  logic               pipe_flush_req,
    input  logic [PC_W-1:0]    pipe_flush_pc,
    output logic               pipe_flush_ack,
    input  logic               ifu_halt_req,
    output logic               ifu_halt_ack
);

    localparam int OW = $clog2(OUTS_MAX + 1);
    localparam int FW = $clog2(FIFO_DEP + 1);
    localparam int SW = $clog2(OUTS_MAX + FIFO_DEP + 1);
    localparam int EW = INSTR_W + PC_W + 2;

    logic            boot_pend;
    logic            stop;
    logic            halt_ack_q;
    logic [PC_W-1:0] fetch_pc;
    logic [OW-1:0]   drop_cnt;
    logic [OW-1:0]   drop_nxt;
    logic [OW-1:0]   outs_tot;
    logic [OW-1:0]   outs_live;
    logic [FW-1:0]   fifo_cnt;
    logic [PC_W-1:0] rsp_pc;
    logic            rsp_hsk;
    logic            rsp_drop;
    logic            rsp_live;
    logic            req_hsk;
    logic            flush_misalgn;
    logic            ir_push;
    logic [EW-1:0]   ir_push_data;
    logic [EW-1:0]   ir_head;
    pc_src_e         pc_src;

    assign ifu_rsp_ready  = 1'b1;
    assign pipe_flush_ack = 1'b1;
    assign ifu_halt_ack   = halt_ack_q;

    // A response with nothing in flight is ignored so the counters can never wrap
    assign rsp_hsk       = ifu_rsp_valid & (outs_tot != '0);
    assign rsp_drop      = rsp_hsk & (drop_cnt != '0);
    assign rsp_live      = rsp_hsk & (drop_cnt == '0);
    assign outs_live     = outs_tot - drop_cnt;
    assign flush_misalgn = pipe_flush_req & (pipe_flush_pc[1:0] != 2'b00);

    assign ifu_req_valid = ~boot_pend & ~stop & ~ifu_halt_req & ~pipe_flush_req
                         & (outs_tot < OW'(OUTS_MAX))
                         & ((SW'(outs_live) + SW'(fifo_cnt)) < SW'(FIFO_DEP));
    assign ifu_req_pc    = fetch_pc;
    assign req_hsk       = ifu_req_valid & ifu_req_ready;

    // Every request, live or later discarded, owns one slot here, so occupancy is the in-flight total
    e203_ifu_ir_fifo #(
        .WIDTH (PC_W),
        .DEPTH (OUTS_MAX)
    ) u_pc_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (1'b0),
        .push      (req_hsk),
        .push_data (fetch_pc),
        .pop       (rsp_hsk),
        .head_data (rsp_pc),
        .count     (outs_tot)
    );

    always_comb begin
        ir_push      = rsp_live;
        ir_push_data = {ifu_rsp_instr, rsp_pc, ifu_rsp_err, 1'b0};
        if (pipe_flush_req) begin
            ir_push      = flush_misalgn;
            ir_push_data = {{INSTR_W{1'b0}}, pipe_flush_pc, 1'b0, 1'b1};
        end
    end

    e203_ifu_ir_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEP)
    ) u_ir_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (pipe_flush_req),
        .push      (ir_push),
        .push_data (ir_push_data),
        .pop       (ifu_o_ready),
        .head_data (ir_head),
        .count     (fifo_cnt)
    );

    assign ifu_o_valid   = (fifo_cnt != '0);
    assign ifu_o_ir      = ir_head[EW-1 -: INSTR_W];
    assign ifu_o_pc      = ir_head[PC_W+1:2];
    assign ifu_o_buserr  = ir_head[1];
    assign ifu_o_misalgn = ir_head[0];

    always_comb begin
        drop_nxt = drop_cnt;
        pc_src   = PC_SRC_HOLD;
        if (pipe_flush_req) begin
            // Everything still in flight after this cycle's response becomes stale
            drop_nxt = outs_tot - OW'(rsp_hsk);
            pc_src   = flush_misalgn ? PC_SRC_HOLD : PC_SRC_FLUSH;
        end else begin
            if (rsp_drop) begin
                drop_nxt = drop_cnt - 1'b1;
            end
            if (boot_pend) begin
                pc_src = PC_SRC_BOOT;
            end else if (req_hsk) begin
                pc_src = PC_SRC_INCR;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            boot_pend  <= 1'b1;
            stop       <= 1'b0;
            halt_ack_q <= 1'b0;
            drop_cnt   <= '0;
            fetch_pc   <= '0;
        end else begin
            // Boot lasts exactly one cycle; a flush in that cycle supplies the PC instead
            boot_pend  <= 1'b0;
            drop_cnt   <= drop_nxt;
            halt_ack_q <= ifu_halt_req & (outs_tot == '0);
            if (pipe_flush_req) begin
                stop <= flush_misalgn;
            end
            case (pc_src)
                PC_SRC_BOOT:  fetch_pc <= {pc_rtvec[PC_W-1:2], 2'b00};
                PC_SRC_FLUSH: fetch_pc <= pipe_flush_pc;
                PC_SRC_INCR:  fetch_pc <= fetch_pc + PC_W'(4);
                default:      fetch_pc <= fetch_pc;
            endcase
        end
    end

endmodule

// File: tb/tb_e203_ifu_prefetch.sv
// tb/tb_e203_ifu_prefetch.sv - self-checking bench for e203_ifu_prefetch
module tb_e203_ifu_prefetch;

    localparam int OUTS_MAX = 2;
    localparam int FIFO_DEP = 4;
    localparam logic [31:0] KEY    = 32'h1357_9BDF;
    localparam logic [31:0] ERR_PC = 32'h0000_0304;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_rtvec;
    logic        ifu_req_valid, ifu_req_ready;
    logic [31:0] ifu_req_pc;
    logic        ifu_rsp_valid, ifu_rsp_ready, ifu_rsp_err;
    logic [31:0] ifu_rsp_instr;
    logic        ifu_o_valid, ifu_o_ready;
    logic [31:0] ifu_o_ir, ifu_o_pc;
    logic        ifu_o_buserr, ifu_o_misalgn;
    logic        pipe_flush_req, pipe_flush_ack;
    logic [31:0] pipe_flush_pc;
    logic        ifu_halt_req, ifu_halt_ack;

    always #5 clk = ~clk;

    e203_ifu_prefetch dut (
        .clk            (clk),
        .rst            (rst),
        .pc_rtvec       (pc_rtvec),
        .ifu_req_valid  (ifu_req_valid),
        .ifu_req_ready  (ifu_req_ready),
        .ifu_req_pc     (ifu_req_pc),
        .ifu_rsp_valid  (ifu_rsp_valid),
        .ifu_rsp_ready  (ifu_rsp_ready),
        .ifu_rsp_err    (ifu_rsp_err),
        .ifu_rsp_instr  (ifu_rsp_instr),
        .ifu_o_valid    (ifu_o_valid),
        .ifu_o_ready    (ifu_o_ready),
        .ifu_o_ir       (ifu_o_ir),
        .ifu_o_pc       (ifu_o_pc),
        .ifu_o_buserr   (ifu_o_buserr),
        .ifu_o_misalgn  (ifu_o_misalgn),
        .pipe_flush_req (pipe_flush_req),
        .pipe_flush_pc  (pipe_flush_pc),
        .pipe_flush_ack (pipe_flush_ack),
        .ifu_halt_req   (ifu_halt_req),
        .ifu_halt_ack   (ifu_halt_ack)
    );

    typedef struct { logic [31:0] pc; bit stale; } fl_t;
    typedef struct { logic [31:0] ir; logic [31:0] pc; bit err; bit mis; } ent_t;

    int total = 0;
    int bad   = 0;

    fl_t         m_fl[$];
    ent_t        m_irq[$];
    bit          m_boot, m_stop, m_ack;
    logic [31:0] m_pc;

    logic [31:0] bus_q[$];
    bit          rsp_en;
    int          n_req;
    logic [31:0] req_log[$];
    ent_t        pop_log[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        int   live;
        bit   ereq, rsp, ack_n;
        fl_t  f;
        ent_t e;
        rsp           = rsp_en && (bus_q.size() > 0);
        ifu_rsp_valid = rsp;
        ifu_rsp_instr = rsp ? (bus_q[0] ^ KEY) : 32'h0;
        ifu_rsp_err   = rsp && (bus_q[0] == ERR_PC);
        #1;
        live = 0;
        foreach (m_fl[i]) if (!m_fl[i].stale) live++;
        ereq = !m_boot && !m_stop && !ifu_halt_req && !pipe_flush_req
             && (m_fl.size() < OUTS_MAX) && (live + m_irq.size() < FIFO_DEP);
        chk("req_valid", ifu_req_valid, ereq);
        if (ereq) chk("req_pc", ifu_req_pc, m_pc);
        chk("o_valid", ifu_o_valid, m_irq.size() > 0);
        if (m_irq.size() > 0) begin
            chk("o_ir", ifu_o_ir, m_irq[0].ir);
            chk("o_pc", ifu_o_pc, m_irq[0].pc);
            chk("o_buserr", ifu_o_buserr, m_irq[0].err);
            chk("o_misalgn", ifu_o_misalgn, m_irq[0].mis);
        end
        chk("halt_ack", ifu_halt_ack, m_ack);
        chk("rsp_ready", ifu_rsp_ready, 1'b1);
        chk("flush_ack", pipe_flush_ack, 1'b1);

        if (ifu_req_valid && ifu_req_ready) begin
            req_log.push_back(ifu_req_pc);
            n_req++;
        end
        if (ifu_o_valid && ifu_o_ready && !pipe_flush_req) begin
            e.ir = ifu_o_ir; e.pc = ifu_o_pc; e.err = ifu_o_buserr; e.mis = ifu_o_misalgn;
            pop_log.push_back(e);
        end
        if (rsp) bus_q.delete(0);
        if (ifu_req_valid && ifu_req_ready) bus_q.push_back(ifu_req_pc);

        ack_n = ifu_halt_req && (m_fl.size() == 0);
        if (m_irq.size() > 0 && ifu_o_ready && !pipe_flush_req) m_irq.delete(0);
        if (rsp && m_fl.size() > 0) begin
            f = m_fl.pop_front();
            if (!f.stale && !pipe_flush_req) begin
                e.ir = f.pc ^ KEY; e.pc = f.pc; e.err = (f.pc == ERR_PC); e.mis = 1'b0;
                m_irq.push_back(e);
            end
        end
        if (pipe_flush_req) begin
            m_irq.delete();
            foreach (m_fl[i]) m_fl[i].stale = 1'b1;
            m_boot = 1'b0;
            if (pipe_flush_pc[1:0] == 2'b00) begin
                m_pc   = pipe_flush_pc;
                m_stop = 1'b0;
            end else begin
                e.ir = 32'h0; e.pc = pipe_flush_pc; e.err = 1'b0; e.mis = 1'b1;
                m_irq.push_back(e);
                m_stop = 1'b1;
            end
        end else if (m_boot) begin
            m_pc   = pc_rtvec & ~32'h3;
            m_boot = 1'b0;
        end else if (ereq && ifu_req_ready) begin
            f.pc = m_pc; f.stale = 1'b0;
            m_fl.push_back(f);
            m_pc = m_pc + 32'd4;
        end
        m_ack = ack_n;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic flush_to(input logic [31:0] target);
        pipe_flush_req = 1'b1;
        pipe_flush_pc  = target;
        step();
        pipe_flush_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int idle, ack, stale;
        rst = 1'b1;
        pc_rtvec = 32'h8000_0002;
        ifu_req_ready = 1'b1; ifu_o_ready = 1'b1;
        ifu_rsp_valid = 1'b0; ifu_rsp_err = 1'b0; ifu_rsp_instr = 32'h0;
        pipe_flush_req = 1'b0; pipe_flush_pc = 32'h0; ifu_halt_req = 1'b0;
        rsp_en = 1'b1; n_req = 0;
        m_boot = 1'b1; m_stop = 1'b0; m_ack = 1'b0; m_pc = 32'h0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_req_valid", ifu_req_valid, 1'b0);
        chk("rst_o_valid", ifu_o_valid, 1'b0);
        chk("rst_halt_ack", ifu_halt_ack, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // 1: boot address alignment and sequential issue, in-flight cap
        repeat (6) step();
        chk("t1_nreq", req_log.size() >= 3, 1'b1);
        if (req_log.size() >= 3) begin
            chk("t1_pc0", req_log[0], 32'h8000_0000);
            chk("t1_pc1", req_log[1], 32'h8000_0004);
            chk("t1_pc2", req_log[2], 32'h8000_0008);
        end
        rsp_en = 1'b0;
        repeat (4) step();
        chk("t1_cap", bus_q.size(), 2);
        rsp_en = 1'b1;

        // 2: backpressure fills the FIFO with exactly FIFO_DEP fetches
        ifu_o_ready = 1'b0;
        flush_to(32'h0000_1000);
        n_req = 0;
        repeat (12) step();
        chk("t2_nreq", n_req, 4);
        chk("t2_req_valid", ifu_req_valid, 1'b0);
        chk("t2_o_valid", ifu_o_valid, 1'b1);
        ifu_o_ready = 1'b1;
        step();
        ifu_o_ready = 1'b0;
        n_req = 0;
        repeat (6) step();
        chk("t2_one_more", n_req, 1);

        // 3: flush with two in flight discards both stale responses
        ifu_o_ready = 1'b1;
        rsp_en = 1'b0;
        repeat (6) step();
        chk("t3_inflight", bus_q.size(), 2);
        rsp_en = 1'b1;
        pop_log.delete();
        flush_to(32'h0000_0100);
        repeat (8) step();
        chk("t3_pops", pop_log.size() > 0, 1'b1);
        if (pop_log.size() > 0) begin
            chk("t3_first_pc", pop_log[0].pc, 32'h0000_0100);
            chk("t3_first_ir", pop_log[0].ir, 32'h0000_0100 ^ KEY);
        end
        stale = 0;
        foreach (pop_log[i]) if (pop_log[i].pc < 32'h100 || pop_log[i].pc >= 32'h200) stale++;
        chk("t3_no_stale", stale, 0);

        // 4: misaligned target yields one marker and stops issue
        ifu_o_ready = 1'b0;
        flush_to(32'h0000_0102);
        n_req = 0;
        repeat (6) step();
        chk("t4_nreq", n_req, 0);
        chk("t4_o_valid", ifu_o_valid, 1'b1);
        chk("t4_o_pc", ifu_o_pc, 32'h0000_0102);
        chk("t4_o_misalgn", ifu_o_misalgn, 1'b1);
        chk("t4_o_ir", ifu_o_ir, 32'h0);
        ifu_o_ready = 1'b1;
        repeat (4) step();
        chk("t4_drained", ifu_o_valid, 1'b0);
        chk("t4_still_stopped", n_req, 0);
        req_log.delete();
        flush_to(32'h0000_0200);
        repeat (3) step();
        chk("t4_resume", req_log.size() > 0, 1'b1);
        if (req_log.size() > 0) chk("t4_resume_pc", req_log[0], 32'h0000_0200);

        // 5: halt waits for in-flight responses, then releases
        rsp_en = 1'b0;
        repeat (4) step();
        chk("t5_inflight", bus_q.size(), 2);
        ifu_halt_req = 1'b1;
        rsp_en = 1'b1;
        n_req = 0;
        idle = -1;
        ack = -1;
        for (int i = 0; i < 20 && ack < 0; i++) begin
            if (idle < 0 && bus_q.size() == 0) idle = i;
            step();
            if (ifu_halt_ack) ack = i + 1;
        end
        chk("t5_ack_seen", ack >= 0, 1'b1);
        chk("t5_ack_lag", ack, idle + 1);
        chk("t5_no_issue", n_req, 0);
        ifu_halt_req = 1'b0;
        step();
        chk("t5_ack_clear", ifu_halt_ack, 1'b0);
        chk("t5_resume", n_req, 1);

        // 6: bus error tagging, flush on a response cycle, back-to-back flushes
        ifu_o_ready = 1'b0;
        flush_to(32'h0000_0300);
        repeat (8) step();
        ifu_o_ready = 1'b1;
        pop_log.delete();
        repeat (4) step();
        chk("t6_pops", pop_log.size() >= 3, 1'b1);
        if (pop_log.size() >= 3) begin
            chk("t6_pc0", pop_log[0].pc, 32'h0000_0300);
            chk("t6_err0", pop_log[0].err, 1'b0);
            chk("t6_err1", pop_log[1].err, 1'b1);
            chk("t6_err2", pop_log[2].err, 1'b0);
        end
        for (int i = 0; i < 10 && bus_q.size() == 0; i++) step();
        chk("t6_rsp_pending", bus_q.size() > 0, 1'b1);
        flush_to(32'h0000_0400);
        repeat (3) step();
        rsp_en = 1'b0;
        repeat (3) step();
        chk("t6_inflight", bus_q.size(), 2);
        flush_to(32'h0000_0440);
        rsp_en = 1'b1;
        pop_log.delete();
        flush_to(32'h0000_0500);
        repeat (8) step();
        chk("t6_b2b_pops", pop_log.size() > 0, 1'b1);
        if (pop_log.size() > 0) chk("t6_b2b_pc", pop_log[0].pc, 32'h0000_0500);
        repeat (4) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
